// File: rtl/uart_bit_sampler_pkg.sv
// Shared types and limits for the UART receive path: FSM state encoding,
// parameter legal ranges and counter-width helpers.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_rx_state_t;

   localparam int OSR_MIN       = 4;
   localparam int OSR_VOTE_MIN  = 8;
   localparam int DATA_BITS_MIN = 5;
   localparam int DATA_BITS_MAX = 9;
   localparam int STOP_BITS_MAX = 2;

   function automatic int cnt_width(input int osr);
      return $clog2(osr);
   endfunction

   // One extra code so the bit index can count all the way to DATA_BITS.
   function automatic int idx_width(input int data_bits);
      return $clog2(data_bits + 1);
   endfunction

endpackage

// File: rtl/uart_bit_sampler_if.sv
// Receive-side bundle between the tick generator / line synchroniser and the
// character consumer. master drives tick and line, slave is the sampler.
interface uart_bit_sampler_if #(
   parameter int DATA_BITS = 8
);
   logic                 sample_tick;
   logic                 rx_in;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output sample_tick, rx_in,
      input  rx_data, rx_valid, frame_err, busy
   );

   modport slave (
      input  sample_tick, rx_in,
      output rx_data, rx_valid, frame_err, busy
   );
endinterface

// File: rtl/uart_bit_sampler_majority3.sv
// uart_majority3: keeps the two previous tick samples of the line and votes
// them 2-of-3 with the live sample, so the vote is valid on the decision tick.
module uart_majority3 (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic sample,
   output logic vote
);
   logic [1:0] hist;

   // Reset to idle-line level so a stale history never fakes a low bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         hist <= 2'b11;
      else if (tick)
         hist <= {hist[0], sample};
   end

   assign vote = (hist[1] & hist[0]) | (hist[1] & sample) | (hist[0] & sample);
endmodule

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: oversampling receive engine (start detect, mid-bit sampling,
// LSB-first shift, framing check). Define UART_MAJORITY_VOTE_EN for 2-of-3 voting.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | line idle; start accepted on a low tick once armed
// ST_START | counting to the middle of the start bit, rejects glitches
// ST_DATA  | one decision per OSR ticks, shifted into the MSB
// ST_STOP  | checks 1..STOP_BITS stop bits, publishes the character
module uart_bit_sampler
   import uart_pkg::*;
#(
   parameter int OSR       = 16,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input logic             clk,
   input logic             rst,
   uart_bit_sampler_if.slave bus
);
   localparam int CNT_W = cnt_width(OSR);
   localparam int IDX_W = idx_width(DATA_BITS);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OSR/2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OSR - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   if (OSR < OSR_MIN || (OSR % 2) != 0) begin : g_bad_osr
      $error("uart_bit_sampler: OSR must be even and at least %0d", OSR_MIN);
   end
   if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
      $error("uart_bit_sampler: DATA_BITS out of range");
   end
   if (STOP_BITS < 1 || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
      $error("uart_bit_sampler: STOP_BITS must be 1 or 2");
   end

   uart_rx_state_t       state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
   logic                 stop_idx, stop_idx_nxt;
   logic                 armed, armed_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_nxt;
   logic                 rx_valid_q, rx_valid_nxt;
   logic                 frame_err_q, frame_err_nxt;
   logic                 dec;

`ifdef UART_MAJORITY_VOTE_EN
   if (OSR < OSR_VOTE_MIN) begin : g_vote_osr
      $error("uart_bit_sampler: majority vote needs OSR >= %0d", OSR_VOTE_MIN);
   end

   uart_majority3 u_vote (
      .clk    (clk),
      .rst    (rst),
      .tick   (bus.sample_tick),
      .sample (bus.rx_in),
      .vote   (dec)
   );
`else
   assign dec = bus.rx_in;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         stop_idx    <= 1'b0;
         armed       <= 1'b0;
         shreg       <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         bit_idx     <= bit_idx_nxt;
         stop_idx    <= stop_idx_nxt;
         armed       <= armed_nxt;
         shreg       <= shreg_nxt;
         rx_data_q   <= rx_data_nxt;
         rx_valid_q  <= rx_valid_nxt;
         frame_err_q <= frame_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      bit_idx_nxt   = bit_idx;
      stop_idx_nxt  = stop_idx;
      armed_nxt     = armed;
      shreg_nxt     = shreg;
      rx_data_nxt   = rx_data_q;
      frame_err_nxt = frame_err_q;
      rx_valid_nxt  = 1'b0;

      if (bus.sample_tick) begin
         if (bus.rx_in)
            armed_nxt = 1'b1;

         case (state)
            ST_IDLE: begin
               if (armed && !bus.rx_in) begin
                  state_nxt = ST_START;
                  cnt_nxt   = '0;
               end
            end
            ST_START: begin
               if (cnt == HALF_LAST) begin
                  cnt_nxt = '0;
                  if (dec) begin
                     state_nxt = ST_IDLE;
                  end else begin
                     bit_idx_nxt = '0;
                     state_nxt   = ST_DATA;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt_nxt     = '0;
                  shreg_nxt   = {dec, shreg[DATA_BITS-1:1]};
                  bit_idx_nxt = bit_idx + 1'b1;
                  if (bit_idx == IDX_LAST) begin
                     stop_idx_nxt = 1'b0;
                     state_nxt    = ST_STOP;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt_nxt = '0;
                  if (dec && STOP_BITS == 2 && !stop_idx) begin
                     stop_idx_nxt = 1'b1;
                  end else begin
                     // A low stop ends the frame early; disarm so a break gives one frame.
                     rx_data_nxt   = shreg;
                     frame_err_nxt = !dec;
                     rx_valid_nxt  = 1'b1;
                     state_nxt     = ST_IDLE;
                     if (!dec)
                        armed_nxt = 1'b0;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = (state != ST_IDLE);
endmodule
